// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the writeback stage.
// Load funct3 encodings, x0 index and FSM state encoding.
package wb_stage_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_align.sv
// Load data lane select and extension.
// Also flags misaligned or illegal load encodings.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            exc
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[{addr_lo, 3'b000} +: 8];
    h    = addr_lo[1] ? rdata[16 +: 16] : rdata[0 +: 16];
    data = '0;
    exc  = 1'b0;
    unique case (1'b1)
      funct3 == F3_LB:  data = {{(XLEN-8){b[7]}}, b};
      funct3 == F3_LBU: data = {{(XLEN-8){1'b0}}, b};
      funct3 == F3_LH: begin
        data = {{(XLEN-16){h[15]}}, h};
        exc  = addr_lo[0];
      end
      funct3 == F3_LHU: begin
        data = {{(XLEN-16){1'b0}}, h};
        exc  = addr_lo[0];
      end
      funct3 == F3_LW: begin
        data = rdata;
        exc  = |addr_lo;
      end
      default: exc = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires mem-stage results, waits on loads,
// drives the regfile write port and counts retired instructions.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  logic            mem_rd_en_i,
  input  logic [4:0]      mem_rd_idx_i,
  input  logic [XLEN-1:0] mem_result_i,
  input  logic            mem_is_load_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic [1:0]      mem_addr_lo_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            rd_en_o,
  output logic [4:0]      rd_idx_o,
  output logic [XLEN-1:0] rd_wdata_o,
  output logic            pend_valid_o,
  output logic [4:0]      pend_idx_o,
  output logic            retire_o,
  output logic            exc_o,
  output logic            resp_err_o,
  output logic [63:0]     instret_o
);

  wb_state_e state, state_nxt;

  logic            p_en;
  logic [4:0]      p_idx;
  logic [2:0]      p_f3;
  logic [1:0]      p_alo;
  logic [XLEN-1:0] la_data;
  logic            la_exc;
  logic            accept;
  logic            resp;

  assign mem_ready_o  = (state == IDLE);
  assign accept       = mem_valid_i & mem_ready_o;
  assign resp         = dmem_rvalid_i & (state == WAIT_RESP);
  assign pend_valid_o = (state == WAIT_RESP)
                      & p_en & (p_idx != REG_X0);
  assign pend_idx_o   = (state == WAIT_RESP) ? p_idx : REG_X0;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3  (p_f3),
    .addr_lo (p_alo),
    .rdata   (dmem_rdata_i),
    .data    (la_data),
    .exc     (la_exc)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (accept && mem_is_load_i) state_nxt = WAIT_RESP;
      WAIT_RESP: if (dmem_rvalid_i) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_en  <= 1'b0;
      p_idx <= '0;
      p_f3  <= '0;
      p_alo <= '0;
    end else if (accept && mem_is_load_i) begin
      p_en  <= mem_rd_en_i;
      p_idx <= mem_rd_idx_i;
      p_f3  <= mem_funct3_i;
      p_alo <= mem_addr_lo_i;
    end
  end

  // Output slot: one-cycle pulses, cleared in every idle cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_o    <= 1'b0;
      rd_idx_o   <= '0;
      rd_wdata_o <= '0;
      retire_o   <= 1'b0;
      exc_o      <= 1'b0;
    end else begin
      rd_en_o    <= 1'b0;
      rd_idx_o   <= '0;
      rd_wdata_o <= '0;
      retire_o   <= 1'b0;
      exc_o      <= 1'b0;
      if (accept && !mem_is_load_i) begin
        rd_en_o    <= mem_rd_en_i & (mem_rd_idx_i != REG_X0);
        rd_idx_o   <= mem_rd_idx_i;
        rd_wdata_o <= mem_result_i;
        retire_o   <= 1'b1;
      end else if (resp) begin
        if (la_exc) begin
          exc_o <= 1'b1;
        end else begin
          rd_en_o    <= p_en & (p_idx != REG_X0);
          rd_idx_o   <= p_idx;
          rd_wdata_o <= la_data;
          retire_o   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_o  <= '0;
      resp_err_o <= 1'b0;
    end else begin
      if (retire_o) instret_o <= instret_o + 64'd1;
      if (dmem_rvalid_i && state != WAIT_RESP) resp_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
// Linear steps with hand-computed expectations.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic        mem_rd_en_i;
  logic [4:0]  mem_rd_idx_i;
  logic [31:0] mem_result_i;
  logic        mem_is_load_i;
  logic [2:0]  mem_funct3_i;
  logic [1:0]  mem_addr_lo_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        rd_en_o;
  logic [4:0]  rd_idx_o;
  logic [31:0] rd_wdata_o;
  logic        pend_valid_o;
  logic [4:0]  pend_idx_o;
  logic        retire_o;
  logic        exc_o;
  logic        resp_err_o;
  logic [63:0] instret_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_valid_i   (mem_valid_i),
    .mem_ready_o   (mem_ready_o),
    .mem_rd_en_i   (mem_rd_en_i),
    .mem_rd_idx_i  (mem_rd_idx_i),
    .mem_result_i  (mem_result_i),
    .mem_is_load_i (mem_is_load_i),
    .mem_funct3_i  (mem_funct3_i),
    .mem_addr_lo_i (mem_addr_lo_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .rd_en_o       (rd_en_o),
    .rd_idx_o      (rd_idx_o),
    .rd_wdata_o    (rd_wdata_o),
    .pend_valid_o  (pend_valid_o),
    .pend_idx_o    (pend_idx_o),
    .retire_o      (retire_o),
    .exc_o         (exc_o),
    .resp_err_o    (resp_err_o),
    .instret_o     (instret_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic en, input logic [4:0] idx,
                     input logic [31:0] res);
    mem_valid_i   = 1'b1;
    mem_is_load_i = 1'b0;
    mem_rd_en_i   = en;
    mem_rd_idx_i  = idx;
    mem_result_i  = res;
  endtask

  // Accept a load, wait one cycle, then pulse rvalid.
  task automatic load(input string tag, input logic [2:0] f3,
                      input logic [1:0] alo, input logic [4:0] idx,
                      input logic [31:0] rdata);
    mem_valid_i   = 1'b1;
    mem_is_load_i = 1'b1;
    mem_rd_en_i   = 1'b1;
    mem_rd_idx_i  = idx;
    mem_funct3_i  = f3;
    mem_addr_lo_i = alo;
    tick();
    mem_valid_i   = 1'b0;
    mem_is_load_i = 1'b0;
    chk({tag, "_ready_wait"}, 64'(mem_ready_o), 64'd0);
    chk({tag, "_pend_valid"}, 64'(pend_valid_o), 64'd1);
    chk({tag, "_pend_idx"}, 64'(pend_idx_o), 64'(idx));
    tick();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    tick();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
  endtask

  logic [63:0] ir;

  initial begin
    reset         = 1'b1;
    mem_valid_i   = 1'b0;
    mem_rd_en_i   = 1'b0;
    mem_rd_idx_i  = '0;
    mem_result_i  = '0;
    mem_is_load_i = 1'b0;
    mem_funct3_i  = '0;
    mem_addr_lo_i = '0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
    tick();
    tick();
    chk("rst_ready", 64'(mem_ready_o), 64'd1);
    chk("rst_rd_en", 64'(rd_en_o), 64'd0);
    chk("rst_wdata", 64'(rd_wdata_o), 64'd0);
    chk("rst_retire", 64'(retire_o), 64'd0);
    chk("rst_instret", instret_o, 64'd0);
    chk("rst_resp_err", 64'(resp_err_o), 64'd0);
    reset = 1'b0;
    tick();

    alu(1'b1, 5'd5, 32'h1234_5678);
    tick();
    mem_valid_i = 1'b0;
    chk("alu_rd_en", 64'(rd_en_o), 64'd1);
    chk("alu_rd_idx", 64'(rd_idx_o), 64'd5);
    chk("alu_wdata", 64'(rd_wdata_o), 64'h1234_5678);
    chk("alu_retire", 64'(retire_o), 64'd1);
    chk("alu_instret0", instret_o, 64'd0);
    tick();
    chk("alu_instret1", instret_o, 64'd1);
    chk("alu_retire_clr", 64'(retire_o), 64'd0);

    load("lb", 3'd0, 2'd3, 5'd7, 32'h80FF_0000);
    chk("lb_wdata", 64'(rd_wdata_o), 64'hFFFF_FF80);
    chk("lb_rd_en", 64'(rd_en_o), 64'd1);
    chk("lb_rd_idx", 64'(rd_idx_o), 64'd7);
    chk("lb_retire", 64'(retire_o), 64'd1);
    chk("lb_ready", 64'(mem_ready_o), 64'd1);
    chk("lb_pend_clr", 64'(pend_valid_o), 64'd0);

    load("lbu", 3'd4, 2'd3, 5'd8, 32'h80FF_0000);
    chk("lbu_wdata", 64'(rd_wdata_o), 64'h0000_0080);
    chk("lbu_instret", instret_o, 64'd2);

    load("lh", 3'd1, 2'd2, 5'd9, 32'h8001_1234);
    chk("lh_wdata", 64'(rd_wdata_o), 64'hFFFF_8001);

    load("lhu", 3'd5, 2'd2, 5'd10, 32'h8001_1234);
    chk("lhu_wdata", 64'(rd_wdata_o), 64'h0000_8001);

    load("lw", 3'd2, 2'd0, 5'd11, 32'hCAFE_BABE);
    chk("lw_wdata", 64'(rd_wdata_o), 64'hCAFE_BABE);
    chk("lw_exc", 64'(exc_o), 64'd0);
    tick();
    chk("loads_instret", instret_o, 64'd6);

    alu(1'b1, 5'd0, 32'hDEAD_BEEF);
    tick();
    mem_valid_i = 1'b0;
    chk("x0_rd_en", 64'(rd_en_o), 64'd0);
    chk("x0_retire", 64'(retire_o), 64'd1);
    tick();
    chk("x0_instret", instret_o, 64'd7);

    alu(1'b1, 5'd1, 32'h0000_0011);
    tick();
    chk("b2b_a_wdata", 64'(rd_wdata_o), 64'h11);
    alu(1'b1, 5'd2, 32'h0000_0022);
    tick();
    mem_valid_i = 1'b0;
    chk("b2b_b_retire", 64'(retire_o), 64'd1);
    chk("b2b_b_wdata", 64'(rd_wdata_o), 64'h22);
    chk("b2b_b_idx", 64'(rd_idx_o), 64'd2);
    tick();
    chk("b2b_instret", instret_o, 64'd9);

    load("lwmis", 3'd2, 2'd2, 5'd12, 32'h1111_2222);
    chk("lwmis_exc", 64'(exc_o), 64'd1);
    chk("lwmis_rd_en", 64'(rd_en_o), 64'd0);
    chk("lwmis_retire", 64'(retire_o), 64'd0);
    tick();
    chk("lwmis_instret", instret_o, 64'd9);
    chk("lwmis_exc_clr", 64'(exc_o), 64'd0);

    load("f3ill", 3'd3, 2'd0, 5'd13, 32'h3333_4444);
    chk("f3ill_exc", 64'(exc_o), 64'd1);
    chk("f3ill_rd_en", 64'(rd_en_o), 64'd0);
    chk("f3ill_retire", 64'(retire_o), 64'd0);
    tick();
    chk("f3ill_instret", instret_o, 64'd9);

    load("lhmis", 3'd1, 2'd1, 5'd14, 32'h5555_6666);
    chk("lhmis_exc", 64'(exc_o), 64'd1);
    chk("lhmis_rd_en", 64'(rd_en_o), 64'd0);

    mem_valid_i   = 1'b1;
    mem_is_load_i = 1'b1;
    mem_rd_en_i   = 1'b1;
    mem_rd_idx_i  = 5'd15;
    mem_funct3_i  = 3'd2;
    mem_addr_lo_i = 2'd0;
    tick();
    mem_valid_i   = 1'b0;
    mem_is_load_i = 1'b0;
    chk("rstw_pend", 64'(pend_valid_o), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw_ready", 64'(mem_ready_o), 64'd1);
    chk("rstw_pend_clr", 64'(pend_valid_o), 64'd0);
    chk("rstw_pend_idx", 64'(pend_idx_o), 64'd0);
    chk("rstw_instret", instret_o, 64'd0);
    chk("rstw_retire", 64'(retire_o), 64'd0);

    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h7777_7777;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("stray_err", 64'(resp_err_o), 64'd1);
    chk("stray_rd_en", 64'(rd_en_o), 64'd0);
    chk("stray_retire", 64'(retire_o), 64'd0);
    chk("stray_ready", 64'(mem_ready_o), 64'd1);
    tick();
    tick();
    chk("stray_sticky", 64'(resp_err_o), 64'd1);
    ir = instret_o;
    chk("stray_instret", ir, 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("stray_rst_clr", 64'(resp_err_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
